// File: rtl/torus_eject_sink_if.sv
// Eject-port bundle between the torus switch (flit source), the
// destination-side sink and its local consumer.
//   master : switch + consumer side (drives flits and out_rdy)
//   slave  : the sink (drives backpressure and the show-ahead head)
interface torus_eject_sink_if #(
  parameter int unsigned X_W = 2,
  parameter int unsigned Y_W = 2,
  parameter int unsigned D_W = 256
);
  logic           in_v;
  logic [X_W-1:0] in_x;
  logic [Y_W-1:0] in_y;
  logic [D_W-1:0] in_data;
  logic           in_b;
  logic           out_v;
  logic [D_W-1:0] out_data;
  logic           out_rdy;

  modport master (
    output in_v, in_x, in_y, in_data, out_rdy,
    input  in_b, out_v, out_data
  );

  modport slave (
    input  in_v, in_x, in_y, in_data, out_rdy,
    output in_b, out_v, out_data
  );
endinterface

// File: rtl/torus_eject_sink.sv
// Destination-side receiver for one torus NoC node. Buffers flits delivered
// on the switch eject port in a small show-ahead FIFO and drives registered
// backpressure toward the switch. The backpressure threshold leaves BP_SLACK
// free slots for flits already on the link. Flits are address-checked against
// this node's coordinates and counted. A RUN/DRAIN/DONE FSM raises done once
// N_PACKETS have been accepted and the buffer has emptied.
module torus_eject_sink #(
  parameter int unsigned X_W       = 2,
  parameter int unsigned Y_W       = 2,
  parameter int unsigned D_W       = 256,
  parameter int unsigned X         = 0,
  parameter int unsigned Y         = 0,
  parameter int unsigned N_PACKETS = 128,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned BP_SLACK  = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  torus_eject_sink_if.slave bus,
  output logic [CNT_W-1:0] rx_count,
  output logic             err_addr,
  output logic             err_ovf,
  output logic             err_extra,
  output logic             done
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned OCC_W = AW + 1;
  // Wide enough to hold N_PACKETS without the compare ever aliasing.
  localparam int unsigned TOT_W = $clog2(N_PACKETS + 1) + 1;

  localparam logic [OCC_W-1:0] DEPTH_C   = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] BP_THRESH = OCC_W'(DEPTH - BP_SLACK);
  localparam logic [TOT_W-1:0] N_C       = TOT_W'(N_PACKETS);
  localparam logic [X_W-1:0]   X_C       = X_W'(X);
  localparam logic [Y_W-1:0]   Y_C       = Y_W'(Y);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  logic [D_W-1:0]   mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [OCC_W-1:0] occ_r;
  logic [TOT_W-1:0] tot_r;
  state_t           state_r;
  logic             out_v_r;
  logic             in_b_r;
  logic             done_r;
  logic [CNT_W-1:0] rx_count_r;
  logic             err_addr_r;
  logic             err_ovf_r;
  logic             err_extra_r;

  logic             addr_ok_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic [OCC_W-1:0] occ_nxt_s;
  logic [TOT_W-1:0] tot_nxt_s;

  // Accept/pop decisions and next occupancy / accepted total.
  always_comb begin
    addr_ok_s = (bus.in_x == X_C) && (bus.in_y == Y_C);
    full_s    = (occ_r == DEPTH_C);
    pop_s     = out_v_r & bus.out_rdy;
    push_s    = bus.in_v & addr_ok_s & (state_r != ST_DONE) & (~full_s | pop_s);
    occ_nxt_s = occ_r;
    tot_nxt_s = tot_r;
    if (push_s && !pop_s) begin
      occ_nxt_s = occ_r + OCC_W'(1);
    end else if (!push_s && pop_s) begin
      occ_nxt_s = occ_r - OCC_W'(1);
    end else begin
      occ_nxt_s = occ_r;
    end
    if (push_s) begin
      tot_nxt_s = tot_r + TOT_W'(1);
    end else begin
      tot_nxt_s = tot_r;
    end
  end

  // Payload storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.in_data;
    end
  end

  // FIFO pointers, occupancy, head-valid, counters and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      occ_r       <= '0;
      tot_r       <= '0;
      out_v_r     <= 1'b0;
      rx_count_r  <= '0;
      err_addr_r  <= 1'b0;
      err_ovf_r   <= 1'b0;
      err_extra_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      occ_r   <= occ_nxt_s;
      tot_r   <= tot_nxt_s;
      out_v_r <= (occ_nxt_s != '0);
      if (push_s && (rx_count_r != '1)) begin
        rx_count_r <= rx_count_r + CNT_W'(1);
      end
      if (bus.in_v && !addr_ok_s) begin
        err_addr_r <= 1'b1;
      end
      if (bus.in_v && full_s && !pop_s) begin
        err_ovf_r <= 1'b1;
      end
      if (bus.in_v && (state_r == ST_DONE)) begin
        err_extra_r <= 1'b1;
      end
    end
  end

  // Completion FSM with registered done and backpressure (forced low in DONE).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_RUN;
      done_r  <= 1'b0;
      in_b_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          // Also covers N_PACKETS==0: the total already matches after reset.
          if (tot_nxt_s == N_C) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_RUN;
          end
          done_r <= 1'b0;
          in_b_r <= (occ_nxt_s >= BP_THRESH);
        end
        ST_DRAIN: begin
          // Judged on next occupancy: a push+pop of the last entry keeps us here.
          if (occ_nxt_s == '0) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            in_b_r  <= 1'b0;
          end else begin
            state_r <= ST_DRAIN;
            done_r  <= 1'b0;
            in_b_r  <= (occ_nxt_s >= BP_THRESH);
          end
        end
        ST_DONE: begin
          state_r <= ST_DONE;
          done_r  <= 1'b1;
          in_b_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_RUN;
          done_r  <= 1'b0;
          in_b_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_b     = in_b_r;
  assign bus.out_v    = out_v_r;
  assign bus.out_data = mem_r[rd_ptr_r];
  assign rx_count     = rx_count_r;
  assign err_addr     = err_addr_r;
  assign err_ovf      = err_ovf_r;
  assign err_extra    = err_extra_r;
  assign done         = done_r;

endmodule

// File: tb/tb_torus_eject_sink.sv
// Bench for torus_eject_sink. Two instances share one stimulus stream:
//   dut_a : N_PACKETS=128, CNT_W=4 (rx_count saturation reachable)
//   dut_b : N_PACKETS=3,   CNT_W=16 (drain / done / extra-flit behaviour)
// Both sit at node (1,2) with DEPTH=4, BP_SLACK=2. The reference model keeps
// a payload queue per instance plus counters and flags.
module tb_torus_eject_sink;

  localparam int NODE_X = 1;
  localparam int NODE_Y = 2;
  localparam int DW     = 32;

  logic clk;
  logic rst;
  logic          in_v;
  logic [1:0]    in_x;
  logic [1:0]    in_y;
  logic [DW-1:0] in_data;
  logic          out_rdy;

  logic [3:0]  rx_a;
  logic [15:0] rx_b;
  logic ea_a, eo_a, ex_a, done_a;
  logic ea_b, eo_b, ex_b, done_b;

  torus_eject_sink_if #(.X_W(2), .Y_W(2), .D_W(DW)) bus_a ();
  torus_eject_sink_if #(.X_W(2), .Y_W(2), .D_W(DW)) bus_b ();

  assign bus_a.in_v = in_v;  assign bus_a.in_x = in_x;  assign bus_a.in_y = in_y;
  assign bus_a.in_data = in_data;  assign bus_a.out_rdy = out_rdy;
  assign bus_b.in_v = in_v;  assign bus_b.in_x = in_x;  assign bus_b.in_y = in_y;
  assign bus_b.in_data = in_data;  assign bus_b.out_rdy = out_rdy;

  torus_eject_sink #(.X_W(2), .Y_W(2), .D_W(DW), .X(NODE_X), .Y(NODE_Y),
    .N_PACKETS(128), .DEPTH(4), .BP_SLACK(2), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .rx_count(rx_a),
    .err_addr(ea_a), .err_ovf(eo_a), .err_extra(ex_a), .done(done_a));

  torus_eject_sink #(.X_W(2), .Y_W(2), .D_W(DW), .X(NODE_X), .Y(NODE_Y),
    .N_PACKETS(3), .DEPTH(4), .BP_SLACK(2), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .rx_count(rx_b),
    .err_addr(ea_b), .err_ovf(eo_b), .err_extra(ex_b), .done(done_b));

  // Observed outputs gathered per instance (index 0 = dut_a, 1 = dut_b).
  logic          o_v [2];
  logic          o_b [2];
  logic          o_ea [2];
  logic          o_eo [2];
  logic          o_ex [2];
  logic          o_done [2];
  logic [DW-1:0] o_data [2];
  logic [15:0]   o_rx [2];

  assign o_v[0] = bus_a.out_v;     assign o_v[1] = bus_b.out_v;
  assign o_b[0] = bus_a.in_b;      assign o_b[1] = bus_b.in_b;
  assign o_data[0] = bus_a.out_data; assign o_data[1] = bus_b.out_data;
  assign o_ea[0] = ea_a;  assign o_ea[1] = ea_b;
  assign o_eo[0] = eo_a;  assign o_eo[1] = eo_b;
  assign o_ex[0] = ex_a;  assign o_ex[1] = ex_b;
  assign o_done[0] = done_a;  assign o_done[1] = done_b;
  assign o_rx[0] = {12'd0, rx_a};  assign o_rx[1] = rx_b;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [DW-1:0] mq [2][$];
  int  m_rx [2];
  int  m_tot [2];
  int  m_n [2]    = '{128, 3};
  int  m_cmax [2] = '{15, 65535};
  bit  m_drain [2];
  bit  m_done [2];
  bit  m_ea [2];
  bit  m_eo [2];
  bit  m_ex [2];

  logic [DW-1:0] sent [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      m_rx[k] = 0; m_tot[k] = 0;
      m_drain[k] = 1'b0; m_done[k] = 1'b0;
      m_ea[k] = 1'b0; m_eo[k] = 1'b0; m_ex[k] = 1'b0;
    end
  endtask

  // One clock of the abstract receiver: a 4-slot queue, counters, flags.
  task automatic model_step();
    bit pop, full, aok, push, was_drain;
    for (int k = 0; k < 2; k++) begin
      pop  = (mq[k].size() > 0) && out_rdy;
      full = (mq[k].size() == 4);
      aok  = (int'(in_x) == NODE_X) && (int'(in_y) == NODE_Y);
      push = in_v && aok && !m_done[k] && (!full || pop);
      if (in_v && !aok) m_ea[k] = 1'b1;
      if (in_v && full && !pop) m_eo[k] = 1'b1;
      if (in_v && m_done[k]) m_ex[k] = 1'b1;
      was_drain = m_drain[k];
      if (pop) void'(mq[k].pop_front());
      if (push) begin
        mq[k].push_back(in_data);
        m_tot[k]++;
        if (m_rx[k] < m_cmax[k]) m_rx[k]++;
      end
      if (m_tot[k] >= m_n[k]) m_drain[k] = 1'b1;
      if (was_drain && (mq[k].size() == 0)) m_done[k] = 1'b1;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_v = 1'b0; out_rdy = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic send_good(input logic [DW-1:0] d);
    in_v = 1'b1; in_x = 2'(NODE_X); in_y = 2'(NODE_Y); in_data = d;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_v = 1'b0; in_x = 2'd0; in_y = 2'd0; in_data = '0; out_rdy = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({o_v[k], o_b[k], o_ea[k], o_eo[k], o_ex[k], o_done[k]} !== 6'b0) begin
        errors++;
        $display("FAIL reset_flags dut%0d got=%b exp=000000", k,
                 {o_v[k], o_b[k], o_ea[k], o_eo[k], o_ex[k], o_done[k]});
      end
      checks++;
      if (o_rx[k] !== 16'd0) begin
        errors++; $display("FAIL reset_rx dut%0d got=%0d exp=0", k, o_rx[k]);
      end
    end
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    do_reset();
    d = $urandom;
    out_rdy = 1'b1;
    send_good(d);
    cycle();
    in_v = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_v[k] !== 1'b1 || o_data[k] !== d) begin
        errors++; $display("FAIL single_head dut%0d got=%b/%h exp=1/%h", k, o_v[k], o_data[k], d);
      end
      checks++;
      if (o_rx[k] !== 16'd1) begin
        errors++; $display("FAIL single_rx dut%0d got=%0d exp=1", k, o_rx[k]);
      end
      checks++;
      if ({o_ea[k], o_eo[k], o_ex[k]} !== 3'b000) begin
        errors++; $display("FAIL single_err dut%0d got=%b exp=000", k, {o_ea[k], o_eo[k], o_ex[k]});
      end
    end
    cycle();
    checks++;
    if (o_v[0] !== 1'b0) begin
      errors++; $display("FAIL single_popped got=%b exp=0", o_v[0]);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sent[i] = $urandom;
      send_good(sent[i]);
      cycle();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_b[k] !== (i >= 1)) begin
          errors++; $display("FAIL bp_in_b dut%0d flit%0d got=%b exp=%b", k, i, o_b[k], (i >= 1));
        end
        checks++;
        if (o_eo[k] !== (i == 4)) begin
          errors++; $display("FAIL bp_ovf dut%0d flit%0d got=%b exp=%b", k, i, o_eo[k], (i == 4));
        end
      end
    end
    in_v = 1'b0;
    checks++;
    if (rx_a !== 4'd4 || rx_b !== 16'd4 || ex_b !== 1'b0) begin
      errors++; $display("FAIL bp_count got=%0d/%0d/%b exp=4/4/0", rx_a, rx_b, ex_b);
    end
    out_rdy = 1'b1;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_v[k] !== 1'b1 || o_data[k] !== sent[j]) begin
          errors++; $display("FAIL bp_order dut%0d idx%0d got=%b/%h exp=1/%h", k, j, o_v[k], o_data[k], sent[j]);
        end
      end
      cycle();
    end
    checks++;
    if (o_v[0] !== 1'b0 || o_v[1] !== 1'b0 || done_b !== 1'b1 || done_a !== 1'b0) begin
      errors++; $display("FAIL bp_drained got=v%b%b done%b%b exp=v00 done01", o_v[0], o_v[1], done_a, done_b);
    end
  endtask

  task automatic test_full_pushpop();
    do_reset();
    for (int i = 0; i < 5; i++) sent[i] = $urandom;
    for (int i = 0; i < 4; i++) begin
      send_good(sent[i]);
      cycle();
    end
    out_rdy = 1'b1;
    send_good(sent[4]);
    cycle();
    in_v = 1'b0;
    checks++;
    if (eo_a !== 1'b0 || rx_a !== 4'd5 || bus_a.in_b !== 1'b1) begin
      errors++; $display("FAIL full_pp got=ovf%b rx%0d b%b exp=ovf0 rx5 b1", eo_a, rx_a, bus_a.in_b);
    end
    for (int j = 1; j < 5; j++) begin
      checks++;
      if (bus_a.out_v !== 1'b1 || bus_a.out_data !== sent[j]) begin
        errors++; $display("FAIL full_pp_order idx%0d got=%b/%h exp=1/%h", j, bus_a.out_v, bus_a.out_data, sent[j]);
      end
      cycle();
    end
    checks++;
    if (bus_a.out_v !== 1'b0) begin
      errors++; $display("FAIL full_pp_occ got=%b exp=0", bus_a.out_v);
    end
  endtask

  task automatic test_bad_addr();
    do_reset();
    in_v = 1'b1; in_x = 2'(NODE_X + 1); in_y = 2'(NODE_Y); in_data = $urandom;
    cycle();
    in_v = 1'b0;
    checks++;
    if (rx_a !== 4'd0 || bus_a.out_v !== 1'b0 || ea_a !== 1'b1) begin
      errors++; $display("FAIL badx got=rx%0d v%b ea%b exp=rx0 v0 ea1", rx_a, bus_a.out_v, ea_a);
    end
    in_v = 1'b1; in_x = 2'(NODE_X); in_y = 2'(NODE_Y + 1);
    cycle();
    send_good($urandom);
    cycle();
    in_v = 1'b0;
    checks++;
    if (rx_a !== 4'd1 || ea_a !== 1'b1 || eo_a !== 1'b0) begin
      errors++; $display("FAIL bad_sticky got=rx%0d ea%b eo%b exp=rx1 ea1 eo0", rx_a, ea_a, eo_a);
    end
  endtask

  task automatic test_drain_done();
    int n;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_good($urandom);
      cycle();
    end
    in_v = 1'b0;
    checks++;
    if (done_b !== 1'b0 || bus_b.in_b !== 1'b1) begin
      errors++; $display("FAIL drain_wait got=done%b b%b exp=done0 b1", done_b, bus_b.in_b);
    end
    out_rdy = 1'b1;
    n = 0;
    while (n < 10 && done_b !== 1'b1) begin
      cycle();
      n++;
    end
    checks++;
    if (done_b !== 1'b1 || n != 3 || bus_b.out_v !== 1'b0) begin
      errors++; $display("FAIL drain_done got=done%b cycles%0d v%b exp=done1 cycles3 v0", done_b, n, bus_b.out_v);
    end
    send_good($urandom);
    cycle();
    in_v = 1'b0;
    checks++;
    if (ex_b !== 1'b1 || bus_b.out_v !== 1'b0 || rx_b !== 16'd3 || bus_b.in_b !== 1'b0 || done_b !== 1'b1) begin
      errors++; $display("FAIL extra got=ex%b v%b rx%0d b%b done%b exp=ex1 v0 rx3 b0 done1",
                         ex_b, bus_b.out_v, rx_b, bus_b.in_b, done_b);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      send_good($urandom);
      cycle();
    end
    send_good($urandom);
    checks++;
    if (bus_a.in_b !== 1'b1 || rx_a !== 4'd2) begin
      errors++; $display("FAIL arst_pre got=b%b rx%0d exp=b1 rx2", bus_a.in_b, rx_a);
    end
    #3;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_v[k] !== 1'b0 || o_b[k] !== 1'b0 || o_rx[k] !== 16'd0 || o_done[k] !== 1'b0) begin
        errors++; $display("FAIL arst_clear dut%0d got=v%b b%b rx%0d d%b exp=all0", k, o_v[k], o_b[k], o_rx[k], o_done[k]);
      end
    end
    in_v = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    cycle();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_v[k] !== 1'b0 || o_rx[k] !== 16'd0) begin
        errors++; $display("FAIL arst_after dut%0d got=v%b rx%0d exp=v0 rx0", k, o_v[k], o_rx[k]);
      end
    end
  endtask

  task automatic test_random();
    bit good;
    bit exp_b;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) do_reset();
      good    = ($urandom_range(0, 99) < 85);
      in_v    = ($urandom_range(0, 9) < 7);
      in_x    = good ? 2'(NODE_X) : 2'($urandom_range(0, 3));
      in_y    = good ? 2'(NODE_Y) : 2'($urandom_range(0, 3));
      in_data = $urandom;
      out_rdy = $urandom_range(0, 1);
      cycle();
      for (int k = 0; k < 2; k++) begin
        exp_b = !m_done[k] && (mq[k].size() >= 2);
        checks++;
        if (o_v[k] !== (mq[k].size() > 0)) begin
          errors++; $display("FAIL rnd_out_v dut%0d cyc%0d got=%b exp=%b", k, i, o_v[k], (mq[k].size() > 0));
        end
        if (mq[k].size() > 0) begin
          checks++;
          if (o_data[k] !== mq[k][0]) begin
            errors++; $display("FAIL rnd_data dut%0d cyc%0d got=%h exp=%h", k, i, o_data[k], mq[k][0]);
          end
        end
        checks++;
        if (o_b[k] !== exp_b) begin
          errors++; $display("FAIL rnd_in_b dut%0d cyc%0d got=%b exp=%b", k, i, o_b[k], exp_b);
        end
        checks++;
        if (o_rx[k] !== 16'(m_rx[k])) begin
          errors++; $display("FAIL rnd_rx dut%0d cyc%0d got=%0d exp=%0d", k, i, o_rx[k], m_rx[k]);
        end
        checks++;
        if ({o_ea[k], o_eo[k], o_ex[k], o_done[k]} !== {m_ea[k], m_eo[k], m_ex[k], m_done[k]}) begin
          errors++; $display("FAIL rnd_flags dut%0d cyc%0d got=%b exp=%b", k, i,
                             {o_ea[k], o_eo[k], o_ex[k], o_done[k]}, {m_ea[k], m_eo[k], m_ex[k], m_done[k]});
        end
      end
    end
    in_v = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_full_pushpop();
    test_bad_addr();
    test_drain_done();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
